// File: rtl/nested_loop_stack.sv
// Hardware loop stack: pushes {pc+1, end, count}, redirects fetch at loop end, pops on final pass.
// Match outputs are combinational from registered state (zero latency); state updates at the edge; no backpressure.
module nested_loop_stack #(
   parameter int ADDR_W = 32,
   parameter int END_W  = 10,
   parameter int CNT_W  = 10,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ADDR_W-1:0]            pc,
   input  logic [END_W-1:0]             instr_end_addr,
   input  logic [CNT_W-1:0]             count,
   input  logic                         en_loop,
   input  logic                         flush,
   output logic                         loop_end_inst,
   output logic                         loop_end_flag,
   output logic                         branch_taken,
   output logic [ADDR_W-1:0]            start_addr,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow
);
   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] start;
      logic [END_W-1:0]  end_addr;
      logic [CNT_W-1:0]  rem;
   } entry_t;

   entry_t          stk_q [DEPTH];
   entry_t          stk_d [DEPTH];
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [IW-1:0]   top_idx, bel_idx;
   entry_t          top_e, bel_e, push_e;

   assign level    = level_q;
   assign overflow = overflow_q;

   always_comb begin
      stk_d         = stk_q;
      level_d       = level_q;
      overflow_d    = overflow_q;
      loop_end_inst = 1'b0;
      loop_end_flag = 1'b0;
      branch_taken  = 1'b0;
      top_idx       = IW'(level_q - LW'(1));
      bel_idx       = IW'(level_q - LW'(2));
      top_e         = stk_q[top_idx];
      bel_e         = stk_q[bel_idx];
      start_addr    = (level_q == '0) ? '0 : top_e.start;
      push_e.start    = pc + ADDR_W'(1);
      push_e.end_addr = instr_end_addr;
      push_e.rem      = (count == '0) ? CNT_W'(1) : count;

      if (flush) begin
         level_d    = '0;
         overflow_d = 1'b0;
      end else if (en_loop) begin
         if (level_q == LW'(DEPTH)) begin
            overflow_d = 1'b1;
         end else begin
            stk_d[IW'(level_q)] = push_e;
            level_d             = level_q + LW'(1);
         end
      end else if (!reset && level_q != '0 && pc[END_W-1:0] == top_e.end_addr) begin
         loop_end_inst = 1'b1;
         if (top_e.rem > CNT_W'(1)) begin
            branch_taken       = 1'b1;
            start_addr         = top_e.start;
            stk_d[top_idx].rem = top_e.rem - CNT_W'(1);
         end else begin
            loop_end_flag = 1'b1;
            level_d       = level_q - LW'(1);
            // Only one level of shared-end cascade: the entry directly below top.
            if (level_q >= LW'(2) && bel_e.end_addr == top_e.end_addr) begin
               if (bel_e.rem > CNT_W'(1)) begin
                  branch_taken       = 1'b1;
                  start_addr         = bel_e.start;
                  stk_d[bel_idx].rem = bel_e.rem - CNT_W'(1);
               end else begin
                  level_d = level_q - LW'(2);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      end else begin
         level_q    <= level_d;
         overflow_q <= overflow_d;
         stk_q      <= stk_d;
      end
   end
endmodule

// File: tb/tb_nested_loop_stack.sv
// Scoreboard bench for nested_loop_stack: queue-based loop model predicts every cycle's outputs.
module tb_nested_loop_stack;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, en_loop, flush;
   logic [31:0] pc;
   logic [9:0]  instr_end_addr, count;
   logic        loop_end_inst, loop_end_flag, branch_taken, overflow;
   logic [31:0] start_addr;
   logic [2:0]  level;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nested_loop_stack dut (
      .clk(clk), .reset(reset), .pc(pc), .instr_end_addr(instr_end_addr), .count(count),
      .en_loop(en_loop), .flush(flush), .loop_end_inst(loop_end_inst),
      .loop_end_flag(loop_end_flag), .branch_taken(branch_taken), .start_addr(start_addr),
      .level(level), .overflow(overflow)
   );

   typedef struct {
      logic [31:0] s;
      logic [9:0]  e;
      int unsigned r;
   } ent_t;

   typedef struct {
      bit          inst, flag, br, ovf;
      logic [31:0] sa;
      int unsigned lvl;
   } exp_t;

   ent_t m_stk[$];
   bit   m_ovf;
   exp_t expq[$];

   logic [31:0] prog_pc  [4];
   logic [9:0]  prog_end [4];
   logic [9:0]  prog_cnt [4];
   int          nprog;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (expq.size() > 0) begin
         x = expq.pop_front();
         chk("loop_end_inst", {31'b0, loop_end_inst}, {31'b0, x.inst});
         chk("loop_end_flag", {31'b0, loop_end_flag}, {31'b0, x.flag});
         chk("branch_taken",  {31'b0, branch_taken},  {31'b0, x.br});
         chk("start_addr",    start_addr,             x.sa);
         chk("level",         {29'b0, level},         x.lvl);
         chk("overflow",      {31'b0, overflow},      {31'b0, x.ovf});
      end
   end

   // Drive one cycle, predict its outputs, then advance the model to the post-edge state.
   task automatic step(input logic [31:0] p, input bit en, input logic [9:0] e,
                       input logic [9:0] c, input bit fl, input bit rs,
                       output bit br_o, output logic [31:0] sa_o);
      ent_t t, b;
      exp_t x;
      int   n;
      @(posedge clk);
      #1;
      pc = p; en_loop = en; instr_end_addr = e; count = c; flush = fl; reset = rs;
      n      = m_stk.size();
      x.lvl  = n;
      x.ovf  = m_ovf;
      x.inst = 0; x.flag = 0; x.br = 0;
      x.sa   = (n == 0) ? 32'h0 : m_stk[n-1].s;
      if (rs || fl) begin
         m_stk.delete();
         m_ovf = 0;
      end else if (en) begin
         if (n == DEPTH) m_ovf = 1;
         else begin
            t.s = p + 1; t.e = e; t.r = (c == 0) ? 1 : c;
            m_stk.push_back(t);
         end
      end else if (n > 0 && p[9:0] == m_stk[n-1].e) begin
         t = m_stk[n-1];
         x.inst = 1;
         if (t.r > 1) begin
            x.br = 1; x.sa = t.s; t.r--; m_stk[n-1] = t;
         end else begin
            x.flag = 1;
            void'(m_stk.pop_back());
            if (n >= 2 && m_stk[n-2].e == t.e) begin
               b = m_stk[n-2];
               if (b.r > 1) begin
                  x.br = 1; x.sa = b.s; b.r--; m_stk[n-2] = b;
               end else begin
                  void'(m_stk.pop_back());
               end
            end
         end
      end
      expq.push_back(x);
      br_o = x.br;
      sa_o = x.sa;
   endtask

   // Fetch model: pc follows predicted redirects; pushes happen at the pcs listed in prog_*.
   task automatic run(input logic [31:0] p0, input int n);
      logic [31:0] p, sa;
      logic [9:0]  e, c;
      bit          en, br;
      p = p0;
      for (int i = 0; i < n; i++) begin
         en = 0; e = 0; c = 0;
         for (int k = 0; k < nprog; k++)
            if (p == prog_pc[k]) begin en = 1; e = prog_end[k]; c = prog_cnt[k]; end
         step(p, en, e, c, 0, 0, br, sa);
         p = br ? sa : p + 1;
      end
   endtask

   task automatic prog(input int k, input logic [31:0] p, input logic [9:0] e, input logic [9:0] c);
      prog_pc[k] = p; prog_end[k] = e; prog_cnt[k] = c;
      if (nprog < k + 1) nprog = k + 1;
   endtask

   initial begin
      bit          br;
      logic [31:0] sa;
      reset = 1; en_loop = 0; flush = 0; pc = 0; instr_end_addr = 0; count = 0;
      m_ovf = 0; nprog = 0;
      repeat (2) @(posedge clk);

      // Post-reset idle outputs, then a single count=3 loop.
      step(32'h0, 0, 0, 0, 0, 0, br, sa);
      nprog = 0; prog(0, 32'h100, 10'h105, 10'd3);
      run(32'h100, 20);

      // Two-level nest with distinct ends.
      nprog = 0; prog(0, 32'h10, 10'h20, 10'd2); prog(1, 32'h12, 10'h18, 10'd2);
      run(32'h10, 60);

      // Shared end address cascade.
      nprog = 0; prog(0, 32'h28, 10'h30, 10'd2); prog(1, 32'h29, 10'h30, 10'd2);
      run(32'h28, 45);

      // Overflow then flush.
      step(32'h3f0, 0, 0, 0, 1, 0, br, sa);
      for (int i = 0; i < 5; i++) step(32'h400 + i, 1, 10'h3ff, 10'd5, 0, 0, br, sa);
      step(32'h410, 0, 0, 0, 0, 0, br, sa);
      step(32'h411, 1, 10'h3ff, 10'd1, 1, 0, br, sa);
      step(32'h412, 0, 0, 0, 0, 0, br, sa);

      // count=0 exits on first match; push coinciding with a match.
      nprog = 0; prog(0, 32'h200, 10'h202, 10'd0);
      run(32'h200, 6);
      nprog = 0; prog(0, 32'h300, 10'h305, 10'd2); prog(1, 32'h305, 10'h3f0, 10'd1);
      run(32'h300, 14);
      step(32'h3f0, 0, 0, 0, 0, 0, br, sa);
      step(32'h305, 0, 0, 0, 0, 0, br, sa);
      step(32'h306, 0, 0, 0, 1, 0, br, sa);

      // Reset with three loops active, then a pc that would have matched.
      nprog = 0;
      prog(0, 32'h500, 10'h510, 10'd3); prog(1, 32'h501, 10'h510, 10'd3); prog(2, 32'h502, 10'h508, 10'd3);
      run(32'h500, 3);
      step(32'h503, 0, 0, 0, 0, 1, br, sa);
      step(32'h508, 0, 0, 0, 0, 0, br, sa);
      step(32'h510, 0, 0, 0, 0, 0, br, sa);

      // Randomized traffic over a small address window to provoke matches and cascades.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(15, 0), ($urandom_range(4, 0) == 0),
              10'($urandom_range(15, 0)), 10'($urandom_range(3, 0)),
              ($urandom_range(29, 0) == 0), ($urandom_range(49, 0) == 0), br, sa);
      end

      @(posedge clk);
      #1;
      en_loop = 0; flush = 0; reset = 0;
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
